// File: rtl/vc_ingress_buffer.sv
// rtl/vc_ingress_buffer.sv - per-port ingress stage: two VC FIFOs, pause/continue flow control, VC0-priority drain
module vc_ingress_buffer #(
    parameter int ADDR_WIDTH = 3,
    parameter int BUS_SIZE   = 5,
    parameter int MEM_LENGTH = 1 << ADDR_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BUS_SIZE:0]   data_in,
    input  logic                valid_in,
    input  logic [3:0]          umbralA,
    input  logic [3:0]          umbralB,
    input  logic                stall_vc0,
    input  logic                stall_vc1,
    output logic [BUS_SIZE-1:0] data_out,
    output logic                valid_out,
    output logic                vc_out,
    output logic                pause_vc0,
    output logic                pause_vc1,
    output logic                continue_vc0,
    output logic                continue_vc1,
    output logic                drop,
    output logic [1:0]          state
);

    localparam logic [1:0] ST_RESET  = 2'd0;
    localparam logic [1:0] ST_INIT   = 2'd1;
    localparam logic [1:0] ST_IDLE   = 2'd2;
    localparam logic [1:0] ST_ACTIVE = 2'd3;

    localparam int              CW     = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]   FULL_C = CW'(MEM_LENGTH);
    localparam logic [CW-1:0]   ONE_C  = CW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [ADDR_WIDTH-1:0] wr0_q, wr0_d, wr1_q, wr1_d;
    logic [ADDR_WIDTH-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic [BUS_SIZE-1:0]   data_out_q, data_out_d;
    logic                  valid_out_q, valid_out_d;
    logic                  vc_out_q, vc_out_d;
    logic                  drop_q, drop_d;
    logic [3:0]            umb_a_q, umb_a_d, umb_b_q, umb_b_d;

    logic [BUS_SIZE-1:0]   mem0_q [MEM_LENGTH];
    logic [BUS_SIZE-1:0]   mem1_q [MEM_LENGTH];

    logic run, wr_req, push0, push1, pop0, pop1;

    always_comb begin
        run    = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
        wr_req = run && valid_in;
        // Fullness uses pre-edge counts: a pop on the same edge never frees a slot for this write.
        push0  = wr_req && !data_in[BUS_SIZE] && (cnt0_q < FULL_C);
        push1  = wr_req &&  data_in[BUS_SIZE] && (cnt1_q < FULL_C);
        pop0   = (cnt0_q != '0) && !stall_vc0;
        pop1   = !pop0 && (cnt1_q != '0) && !stall_vc1;

        cnt0_d = cnt0_q;
        if (push0 && !pop0)      cnt0_d = cnt0_q + ONE_C;
        else if (!push0 && pop0) cnt0_d = cnt0_q - ONE_C;
        cnt1_d = cnt1_q;
        if (push1 && !pop1)      cnt1_d = cnt1_q + ONE_C;
        else if (!push1 && pop1) cnt1_d = cnt1_q - ONE_C;

        wr0_d = push0 ? wr0_q + PTR_ONE : wr0_q;
        wr1_d = push1 ? wr1_q + PTR_ONE : wr1_q;
        rd0_d = pop0  ? rd0_q + PTR_ONE : rd0_q;
        rd1_d = pop1  ? rd1_q + PTR_ONE : rd1_q;

        data_out_d  = data_out_q;
        vc_out_d    = vc_out_q;
        valid_out_d = pop0 || pop1;
        if (pop0) begin
            data_out_d = mem0_q[rd0_q];
            vc_out_d   = 1'b0;
        end else if (pop1) begin
            data_out_d = mem1_q[rd1_q];
            vc_out_d   = 1'b1;
        end

        drop_d  = wr_req && !push0 && !push1;
        umb_a_d = (state_q == ST_INIT) ? umbralA : umb_a_q;
        umb_b_d = (state_q == ST_INIT) ? umbralB : umb_b_q;

        state_d = state_q;
        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE:   if (push0 || push1) state_d = ST_ACTIVE;
            ST_ACTIVE: if (cnt0_d == '0 && cnt1_d == '0) state_d = ST_IDLE;
            default:   state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RESET;
            cnt0_q      <= '0;
            cnt1_q      <= '0;
            wr0_q       <= '0;
            wr1_q       <= '0;
            rd0_q       <= '0;
            rd1_q       <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            vc_out_q    <= 1'b0;
            drop_q      <= 1'b0;
            umb_a_q     <= '0;
            umb_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt0_q      <= cnt0_d;
            cnt1_q      <= cnt1_d;
            wr0_q       <= wr0_d;
            wr1_q       <= wr1_d;
            rd0_q       <= rd0_d;
            rd1_q       <= rd1_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            vc_out_q    <= vc_out_d;
            drop_q      <= drop_d;
            umb_a_q     <= umb_a_d;
            umb_b_q     <= umb_b_d;
        end
    end

    // Storage is not reset; stale words are unreachable once the pointers and counts clear.
    always_ff @(posedge clk) begin
        if (push0) mem0_q[wr0_q] <= data_in[BUS_SIZE-1:0];
        if (push1) mem1_q[wr1_q] <= data_in[BUS_SIZE-1:0];
    end

    assign data_out     = data_out_q;
    assign valid_out    = valid_out_q;
    assign vc_out       = vc_out_q;
    assign drop         = drop_q;
    assign state        = state_q;
    assign pause_vc0    = run && (32'(cnt0_q) >= 32'(umb_a_q));
    assign pause_vc1    = run && (32'(cnt1_q) >= 32'(umb_a_q));
    assign continue_vc0 = !run || (32'(cnt0_q) <= 32'(umb_b_q));
    assign continue_vc1 = !run || (32'(cnt1_q) <= 32'(umb_b_q));

endmodule

// File: tb/tb_vc_ingress_buffer.sv
// tb/tb_vc_ingress_buffer.sv - scoreboard bench for vc_ingress_buffer
module tb_vc_ingress_buffer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] data_in = '0;
    logic       valid_in = 1'b0;
    logic [3:0] umbralA = 4'd6;
    logic [3:0] umbralB = 4'd3;
    logic       stall_vc0 = 1'b0;
    logic       stall_vc1 = 1'b0;
    logic [4:0] data_out;
    logic       valid_out, vc_out, drop;
    logic       pause_vc0, pause_vc1, continue_vc0, continue_vc1;
    logic [1:0] state;

    vc_ingress_buffer #(.ADDR_WIDTH(3), .BUS_SIZE(5)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .umbralA(umbralA), .umbralB(umbralB), .stall_vc0(stall_vc0), .stall_vc1(stall_vc1),
        .data_out(data_out), .valid_out(valid_out), .vc_out(vc_out),
        .pause_vc0(pause_vc0), .pause_vc1(pause_vc1),
        .continue_vc0(continue_vc0), .continue_vc1(continue_vc1),
        .drop(drop), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic       vc;
        logic [4:0] data;
        logic       drop;
        logic       pa0, pa1, co0, co1;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [4:0] m0[$];
    logic [4:0] m1[$];
    int         umb_a = 6;
    int         umb_b = 3;
    int         tests_run = 0;
    int         tests_failed = 0;
    logic [1:0] init_state;
    logic       init_pause, init_cont;

    // Reference model: predicts the outcome of one edge, posts it to the scoreboard after the edge.
    task automatic cycle(input logic wr, input logic [5:0] w, input logic s0, input logic s1);
        exp_t e;
        logic p0, p1, acc;
        valid_in = wr; data_in = w; stall_vc0 = s0; stall_vc1 = s1;
        p0 = (m0.size() > 0) && !s0;
        p1 = !p0 && (m1.size() > 0) && !s1;
        e.valid = p0 | p1;
        e.vc    = p1;
        e.data  = p0 ? m0[0] : (p1 ? m1[0] : 5'd0);
        e.drop  = wr && ((w[5] ? m1.size() : m0.size()) >= 8);
        acc     = wr && !e.drop;
        if (p0) void'(m0.pop_front());
        if (p1) void'(m1.pop_front());
        if (acc) begin
            if (w[5]) m1.push_back(w[4:0]);
            else      m0.push_back(w[4:0]);
        end
        e.pa0 = m0.size() >= umb_a;
        e.pa1 = m1.size() >= umb_a;
        e.co0 = m0.size() <= umb_b;
        e.co1 = m1.size() <= umb_b;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic release_reset(input logic [3:0] ua, input logic [3:0] ub, input logic init_valid);
        umbralA = ua; umbralB = ub;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        init_state = state; init_pause = pause_vc0; init_cont = continue_vc0;
        valid_in = init_valid; data_in = 6'b000101;
        @(posedge clk); #1;
        valid_in = 1'b0;
        umb_a = ua; umb_b = ub;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            tests_run++;
            if (valid_out !== mon_e.valid) begin
                tests_failed++; $display("FAIL sb_valid: got %b want %b at %0t", valid_out, mon_e.valid, $time);
            end
            if (mon_e.valid) begin
                tests_run++;
                if (vc_out !== mon_e.vc || data_out !== mon_e.data) begin
                    tests_failed++;
                    $display("FAIL sb_word: got vc=%b data=%h want vc=%b data=%h at %0t", vc_out, data_out, mon_e.vc, mon_e.data, $time);
                end
            end
            tests_run++;
            if (drop !== mon_e.drop) begin
                tests_failed++; $display("FAIL sb_drop: got %b want %b at %0t", drop, mon_e.drop, $time);
            end
            tests_run++;
            if ({pause_vc0, pause_vc1, continue_vc0, continue_vc1} !== {mon_e.pa0, mon_e.pa1, mon_e.co0, mon_e.co1}) begin
                tests_failed++;
                $display("FAIL sb_flow: got p0p1c0c1=%b%b%b%b want %b%b%b%b at %0t", pause_vc0, pause_vc1, continue_vc0, continue_vc1,
                         mon_e.pa0, mon_e.pa1, mon_e.co0, mon_e.co1, $time);
            end
        end
    end

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        tests_run++;
        if ({state, valid_out, vc_out, drop, data_out} !== 10'b0) begin
            tests_failed++; $display("FAIL reset_outputs: got state=%0d v=%b vc=%b drop=%b data=%h want all 0", state, valid_out, vc_out, drop, data_out);
        end
        tests_run++;
        if ({pause_vc0, pause_vc1, continue_vc0, continue_vc1} !== 4'b0011) begin
            tests_failed++; $display("FAIL reset_flow: got %b%b%b%b want 0011", pause_vc0, pause_vc1, continue_vc0, continue_vc1);
        end
        release_reset(4'd6, 4'd3, 1'b0);
        tests_run++;
        if (init_state !== 2'd1 || init_pause !== 1'b0 || init_cont !== 1'b1) begin
            tests_failed++; $display("FAIL init_phase: got state=%0d p=%b c=%b want 1 0 1", init_state, init_pause, init_cont);
        end
        tests_run++;
        if (state !== 2'd2) begin
            tests_failed++; $display("FAIL idle_after_init: got %0d want 2", state);
        end
    endtask

    task automatic test_passthrough();
        cycle(1'b1, 6'b011011, 1'b0, 1'b0);
        tests_run++;
        if (state !== 2'd3) begin
            tests_failed++; $display("FAIL pt_active: got %0d want 3", state);
        end
        cycle(1'b0, 6'd0, 1'b0, 1'b0);
        tests_run++;
        if (valid_out !== 1'b1 || data_out !== 5'b11011 || vc_out !== 1'b0 || state !== 2'd2) begin
            tests_failed++; $display("FAIL pt_word: got v=%b data=%b vc=%b state=%0d want 1 11011 0 2", valid_out, data_out, vc_out, state);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, {1'b0, 5'(i + 1)}, 1'b1, 1'b0);
            tests_run++;
            if (pause_vc0 !== (i + 1 >= 6) || continue_vc0 !== (i + 1 <= 3)) begin
                tests_failed++; $display("FAIL fill_flow_%0d: got p=%b c=%b want %b %b", i + 1, pause_vc0, continue_vc0, (i + 1 >= 6), (i + 1 <= 3));
            end
        end
        cycle(1'b1, 6'd20, 1'b1, 1'b0);
        tests_run++;
        if (drop !== 1'b1 || pause_vc0 !== 1'b1) begin
            tests_failed++; $display("FAIL fill_drop: got drop=%b pause=%b want 1 1", drop, pause_vc0);
        end
        cycle(1'b0, 6'd0, 1'b1, 1'b0);
        tests_run++;
        if (drop !== 1'b0) begin
            tests_failed++; $display("FAIL fill_drop_pulse: got %b want 0", drop);
        end
        cycle(1'b1, 6'd21, 1'b0, 1'b0);
        tests_run++;
        if (drop !== 1'b1 || valid_out !== 1'b1 || data_out !== 5'd1) begin
            tests_failed++; $display("FAIL full_push_pop: got drop=%b v=%b data=%h want 1 1 01", drop, valid_out, data_out);
        end
        repeat (7) cycle(1'b0, 6'd0, 1'b0, 1'b0);
        tests_run++;
        if (state !== 2'd2) begin
            tests_failed++; $display("FAIL fill_idle: got %0d want 2", state);
        end
    endtask

    task automatic test_priority();
        logic [5:0] got[4];
        logic [5:0] want[4];
        want[0] = 6'h03; want[1] = 6'h04; want[2] = 6'h27; want[3] = 6'h28;
        cycle(1'b1, 6'h03, 1'b1, 1'b1);
        cycle(1'b1, 6'h27, 1'b1, 1'b1);
        cycle(1'b1, 6'h04, 1'b1, 1'b1);
        cycle(1'b1, 6'h28, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 6'd0, 1'b0, 1'b0);
            got[i] = {vc_out, data_out};
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (got[i] !== want[i]) begin
                tests_failed++; $display("FAIL prio_order_%0d: got %h want %h", i, got[i], want[i]);
            end
        end
        tests_run++;
        if (state !== 2'd2) begin
            tests_failed++; $display("FAIL prio_idle: got %0d want 2", state);
        end
    endtask

    task automatic test_stall_bypass();
        cycle(1'b1, 6'h09, 1'b1, 1'b1);
        cycle(1'b1, 6'h2a, 1'b1, 1'b1);
        cycle(1'b0, 6'd0, 1'b1, 1'b0);
        tests_run++;
        if (valid_out !== 1'b1 || vc_out !== 1'b1 || data_out !== 5'h0a) begin
            tests_failed++; $display("FAIL bypass_vc1: got v=%b vc=%b data=%h want 1 1 0a", valid_out, vc_out, data_out);
        end
        cycle(1'b0, 6'd0, 1'b0, 1'b0);
        tests_run++;
        if (valid_out !== 1'b1 || vc_out !== 1'b0 || data_out !== 5'h09 || state !== 2'd2) begin
            tests_failed++; $display("FAIL bypass_vc0: got v=%b vc=%b data=%h st=%0d want 1 0 09 2", valid_out, vc_out, data_out, state);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 6'h20, 1'b0, 1'b1);
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, {1'b1, 5'(i)}, 1'b0, 1'b0);
            tests_run++;
            if (valid_out !== 1'b1 || vc_out !== 1'b1 || data_out !== 5'(i - 1) || pause_vc1 !== 1'b0 || continue_vc1 !== 1'b1) begin
                tests_failed++;
                $display("FAIL wrap_%0d: got v=%b vc=%b data=%h p=%b c=%b want 1 1 %h 0 1", i, valid_out, vc_out, data_out, pause_vc1, continue_vc1, 5'(i - 1));
            end
        end
        cycle(1'b0, 6'd0, 1'b0, 1'b0);
        tests_run++;
        if (data_out !== 5'd20 || state !== 2'd2) begin
            tests_failed++; $display("FAIL wrap_drain: got data=%h st=%0d want 14 2", data_out, state);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 6'h36, 1'b0, 1'b1);
        cycle(1'b1, 6'h11, 1'b1, 1'b0);
        tests_run++;
        if (valid_out !== 1'b1 || data_out !== 5'h16) begin
            tests_failed++; $display("FAIL pre_reset: got v=%b data=%h want 1 16", valid_out, data_out);
        end
        exp_q.delete(); m0.delete(); m1.delete();
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if ({state, valid_out, vc_out, drop, data_out, pause_vc0, pause_vc1} !== 12'b0) begin
            tests_failed++; $display("FAIL async_reset: got state=%0d v=%b vc=%b drop=%b data=%h p0=%b p1=%b want all 0",
                                     state, valid_out, vc_out, drop, data_out, pause_vc0, pause_vc1);
        end
        release_reset(4'd6, 4'd3, 1'b1);
        tests_run++;
        if (state !== 2'd2 || drop !== 1'b0) begin
            tests_failed++; $display("FAIL init_ignore: got state=%0d drop=%b want 2 0", state, drop);
        end
        umbralA = 4'd2;
        cycle(1'b0, 6'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, {1'b0, 5'(i + 24)}, 1'b1, 1'b0);
        tests_run++;
        if (pause_vc0 !== 1'b0) begin
            tests_failed++; $display("FAIL thresh_locked: got pause=%b want 0", pause_vc0);
        end
        repeat (3) cycle(1'b0, 6'd0, 1'b0, 1'b0);
        tests_run++;
        if (state !== 2'd2) begin
            tests_failed++; $display("FAIL reset_drain: got %0d want 2", state);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_fill();
        test_priority();
        test_stall_bypass();
        test_wrap();
        test_async_reset();
        @(negedge clk);
        #1;
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++; $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
